// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: first-word-fall-through FIFO; dout shows the head word whenever empty is low.
module fallthrough_small_fifo #(
  parameter int WIDTH = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    nearly_full,
  output logic                    prog_full,
  output logic                    empty,
  output logic [MAX_DEPTH_BITS:0] data_count
);
  localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NEAR_LVL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0] PROG_LVL = (MAX_DEPTH_BITS + 1)'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      wr_ok;
  logic                      rd_ok;

  // acceptance depends only on registered occupancy, so status never sees wr_en/rd_en combinationally
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign dout        = mem[rd_ptr];
  assign data_count  = count;
  assign full        = count == FULL_LVL;
  assign nearly_full = count >= NEAR_LVL;
  assign prog_full   = count >= PROG_LVL;
  assign empty       = count == '0;

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// tb_fallthrough_small_fifo: directed and randomized checks against a queue model of the FIFO.
module tb_fallthrough_small_fifo;
  localparam int W = 72;
  localparam int B = 2;
  localparam int D = 4;
  localparam int T = 3;

  logic clk = 0;
  logic reset = 0;
  logic wr_en = 0;
  logic rd_en = 0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic full, nearly_full, prog_full, empty;
  logic [B:0] data_count;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] q[$];

  fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(B), .PROG_FULL_THRESHOLD(T)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
    .full(full), .nearly_full(nearly_full), .prog_full(prog_full), .empty(empty),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, W'(data_count), W'(n));
    check({tag, ".empty"}, W'(empty), W'(n == 0));
    check({tag, ".full"}, W'(full), W'(n == D));
    check({tag, ".nfull"}, W'(nearly_full), W'(n >= D - 1));
    check({tag, ".pfull"}, W'(prog_full), W'(n >= T));
    if (n > 0) check({tag, ".dout"}, dout, q[0]);
  endtask

  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input string tag);
    bit wa, ra;
    wr_en = w;
    rd_en = r;
    din = d;
    @(posedge clk);
    if (reset) begin
      wa = w && q.size() < D;
      ra = r && q.size() > 0;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    #1;
    wr_en = 0;
    rd_en = 0;
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    reset = 0;
    q.delete();
    #1;
    check({tag, ".empty_now"}, W'(empty), W'(1));
    check({tag, ".count_now"}, W'(data_count), W'(0));
    check_state(tag);
    step(1, 1, 72'hdead, {tag, ".held"});
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset = 1;

    step(1, 0, 72'h01_0000000000000001, "r31");
    check("r31.dout", dout, 72'h01_0000000000000001);
    step(0, 1, '0, "r31.drain");

    for (int i = 1; i <= 4; i++) step(1, 0, W'(i), $sformatf("r32.w%0d", i));
    check("r32.full", W'(full), W'(1));
    step(1, 0, W'(5), "r32.w5");
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("r32.head%0d", i), dout, W'(i));
      step(0, 1, '0, $sformatf("r32.r%0d", i));
    end
    check("r32.empty", W'(empty), W'(1));

    step(1, 0, W'(100), "r33.f0");
    step(1, 0, W'(101), "r33.f1");
    for (int i = 0; i < 10; i++) step(1, 1, W'(102 + i), $sformatf("r33.c%0d", i));
    check("r33.count", W'(data_count), W'(2));
    step(0, 1, '0, "r33.d0");
    step(0, 1, '0, "r33.d1");

    step(0, 1, '0, "r34.rd_empty");
    step(1, 1, W'(9), "r34.wr_rd_empty");
    check("r34.dout", dout, W'(9));
    step(0, 1, '0, "r34.drain");

    for (int i = 0; i < 4; i++) step(1, 0, W'(20 + i), "r35.fill");
    step(1, 1, W'(99), "r35.both");
    check("r35.count", W'(data_count), W'(3));
    check("r35.full", W'(full), W'(0));

    async_reset("r36");
    for (int i = 0; i < 2; i++) step(0, 1, '0, "r36.drain");
    for (int i = 0; i < 3; i++) step(1, 0, W'(40 + i), "r36.fill");
    async_reset("r36b");
    step(1, 0, W'(7), "r36.w7");
    check("r36.dout7", dout, W'(7));
    step(0, 1, '0, "r36.r7");

    for (int i = 0; i < 600; i++) begin
      int wb;
      wb = (i / 100) % 2 ? 70 : 35;
      if ($urandom_range(0, 199) == 0) async_reset("rnd.rst");
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < 50,
           {$urandom, $urandom, $urandom}, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
